// File: rtl/bit_serial_deser.sv
// bit_serial_deser: reassembles an LSB-first bit stream into WIDTH-bit words
// and presents each word on a valid/ready holding register. It flags framing
// errors (sof arriving mid-word) and overruns (a completed word dropped).
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-low reset
//   bit_in     serial data bit, LSB first
//   bit_valid  bit_in is valid this cycle
//   sof        start of frame, qualifies a valid bit as bit 0
//   clr_err    synchronous clear of the sticky error flags
//   out_data   assembled word, stable while out_valid=1
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer accepts out_data when out_valid=1
//   busy       a word is partially received
//   frame_err  sticky, sof arrived mid-word
//   overrun    sticky, a completed word was dropped
module bit_serial_deser #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             sof,
  input  logic             clr_err,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ovalid_q, ovalid_d;
  logic             busy_q;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             complete;
  logic [WIDTH-1:0] word;

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      data_q   <= '0;
      ovalid_q <= 1'b0;
      busy_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      ovalid_q <= ovalid_d;
      busy_q   <= (state_d == SHIFT);
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  // Next-state, shift, output-stage and flag logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    ovalid_d = ovalid_q;
    ferr_d   = ferr_q;
    ovr_d    = ovr_q;
    complete = 1'b0;
    word     = shreg_q | (WIDTH'(bit_in) << cnt_q);

    // Clear first so a same-cycle set event below wins
    if (clr_err) begin
      ferr_d = 1'b0;
      ovr_d  = 1'b0;
    end

    if (ovalid_q && out_ready) begin
      ovalid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // Non-sof bits in IDLE are silently discarded
        if (bit_valid && sof) begin
          shreg_d = WIDTH'(bit_in);
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          if (sof) begin
            // Restart on the new frame; upper bits cleared with the partial
            ferr_d  = 1'b1;
            shreg_d = WIDTH'(bit_in);
            cnt_d   = CW'(1);
          end else begin
            shreg_d = word;
            if (cnt_q == LAST) begin
              complete = 1'b1;
              cnt_d    = '0;
              state_d  = IDLE;
            end else begin
              cnt_d = CW'(cnt_q + 1'b1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Holding register loads when empty or being drained this same edge
    if (complete) begin
      if (!ovalid_q || out_ready) begin
        data_d   = word;
        ovalid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign out_data  = data_q;
  assign out_valid = ovalid_q;
  assign busy      = busy_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_bit_serial_deser.sv
// Self-checking bench for bit_serial_deser (WIDTH=8) with a word scoreboard.
module tb_bit_serial_deser;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in, bit_valid, sof, clr_err, out_ready;
  logic [7:0] out_data;
  logic       out_valid, busy, frame_err, overrun;

  int checks   = 0;
  int failures = 0;
  logic [7:0] sb[$];

  bit_serial_deser #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .sof       (sof),
    .clr_err   (clr_err),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, return 1 time unit after the edge
  task automatic drive_bit(input logic b, input logic s, input logic v);
    bit_in    = b;
    sof       = s;
    bit_valid = v;
    @(posedge clk);
    #1;
  endtask

  // Send a full word; optional gap after bit index gap_at; optionally raise
  // out_ready in the last-bit cycle. Checks busy after every edge.
  task automatic send_word(input logic [7:0] w, input int gap_at, input int gap_len,
                           input logic rdy_last);
    for (int i = 0; i < 8; i++) begin
      if (i == 7 && rdy_last) out_ready = 1'b1;
      drive_bit(w[i], i == 0, 1'b1);
      chk("busy_bit", 32'(busy), 32'(i < 7));
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          drive_bit(1'b0, 1'b0, 1'b0);
          chk("busy_gap", 32'(busy), 32'd1);
          chk("valid_gap", 32'(out_valid), 32'd0);
        end
      end
    end
    bit_valid = 1'b0;
    sof       = 1'b0;
  endtask

  // Scoreboard: a word is consumed on the edge after a valid&ready sample
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_extra_word", 32'(out_valid), 32'd0);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        chk("sb_word", 32'(out_data), 32'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; sof = 1'b0;
    clr_err = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic word
    sb.push_back(8'h5A);
    send_word(8'h5A, -1, 0, 1'b0);
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_data", 32'(out_data), 32'h5A);
    drive_bit(1'b0, 1'b0, 1'b0);
    chk("basic_valid_drop", 32'(out_valid), 32'd0);
    chk("basic_data_hold", 32'(out_data), 32'h5A);
    chk("basic_ferr", 32'(frame_err), 32'd0);
    chk("basic_ovr", 32'(overrun), 32'd0);

    // Gapped input: 3 idle cycles after bit 3
    sb.push_back(8'h5A);
    send_word(8'h5A, 3, 3, 1'b0);
    chk("gap_valid", 32'(out_valid), 32'd1);
    chk("gap_data", 32'(out_data), 32'h5A);
    drive_bit(1'b0, 1'b0, 1'b0);

    // Frame error: partial 4 bits, then a fresh sof word
    for (int i = 0; i < 4; i++) drive_bit(1'b1, i == 0, 1'b1);
    chk("ferr_before", 32'(frame_err), 32'd0);
    sb.push_back(8'hC3);
    send_word(8'hC3, 0, 0, 1'b0);
    chk("ferr_set", 32'(frame_err), 32'd1);
    chk("ferr_data", 32'(out_data), 32'hC3);
    clr_err = 1'b1;
    drive_bit(1'b0, 1'b0, 1'b0);
    clr_err = 1'b0;
    chk("ferr_clr", 32'(frame_err), 32'd0);

    // Overrun: back-to-back words with out_ready low; second is dropped
    out_ready = 1'b0;
    sb.push_back(8'h11);
    send_word(8'h11, -1, 0, 1'b0);
    send_word(8'h22, -1, 0, 1'b0);
    chk("ovr_data", 32'(out_data), 32'h11);
    chk("ovr_valid", 32'(out_valid), 32'd1);
    chk("ovr_flag", 32'(overrun), 32'd1);
    drive_bit(1'b0, 1'b0, 1'b0);
    chk("ovr_hold_data", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    drive_bit(1'b0, 1'b0, 1'b0);
    chk("ovr_accept", 32'(out_valid), 32'd0);
    clr_err = 1'b1;
    drive_bit(1'b0, 1'b0, 1'b0);
    clr_err = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);

    // Simultaneous accept and complete
    out_ready = 1'b0;
    sb.push_back(8'h11);
    sb.push_back(8'h22);
    send_word(8'h11, -1, 0, 1'b0);
    drive_bit(1'b0, 1'b0, 1'b0);
    send_word(8'h22, -1, 0, 1'b1);
    chk("sim_data", 32'(out_data), 32'h22);
    chk("sim_valid", 32'(out_valid), 32'd1);
    chk("sim_ovr", 32'(overrun), 32'd0);
    drive_bit(1'b0, 1'b0, 1'b0);
    chk("sim_drain", 32'(out_valid), 32'd1 - 32'd1);

    // Async reset mid-word with a pending word
    out_ready = 1'b0;
    send_word(8'hA5, -1, 0, 1'b0);
    for (int i = 0; i < 5; i++) drive_bit(1'b1, i == 0, 1'b1);
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    chk("ar_pre_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_data", 32'(out_data), 32'd0);
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_ferr", 32'(frame_err), 32'd0);
    chk("ar_ovr", 32'(overrun), 32'd0);
    bit_valid = 1'b0;
    sof = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    drive_bit(1'b1, 1'b0, 1'b1);
    chk("ar_stray_busy", 32'(busy), 32'd0);
    chk("ar_stray_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    sb.push_back(8'hFF);
    send_word(8'hFF, -1, 0, 1'b0);
    chk("ar_ff_data", 32'(out_data), 32'hFF);
    chk("ar_ff_valid", 32'(out_valid), 32'd1);

    repeat (3) drive_bit(1'b0, 1'b0, 1'b0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_serial_deser.md
# bit_serial_deser

- Receives an LSB-first bit stream from the bit-level pipelined datapath and reassembles it into WIDTH-bit parallel words.
- Each word is presented on a valid/ready output holding register.
- Counterpart of the bit-serial transmit/stimulus side: it sits at the sink end of a bit-serial link and flags framing and overrun errors.

## Interface

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- bit_in  input  1  serial data bit, LSB first.
- bit_valid  input  1  bit_in is valid this cycle.
- sof  input  1  start of frame; qualifies a valid bit as bit 0 of a new word. Ignored when bit_valid=0.
- clr_err  input  1  synchronous clear of the sticky error flags.
- out_data  output  WIDTH  assembled word; stable while out_valid=1.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data when out_valid=1 on a clock edge.
- busy  output  1  a word is partially received (state SHIFT).
- frame_err  output  1  sticky; set when sof arrives mid-word.
- overrun  output  1  sticky; set when a completed word is dropped.

## Operation

Reset values (rst=0): out_data=0, out_valid=0, busy=0, frame_err=0, overrun=0. The shift register, the bit counter (clog2(WIDTH) bits) and the state return to IDLE.

State IDLE:
- bit_valid=1 and sof=1: capture bit_in as bit 0, set count=1, go to SHIFT.
- bit_valid=1 and sof=0: bit discarded; no flag set.

State SHIFT:
- bit_valid=1 and sof=0: store bit_in at position count, then increment count.
- If count was WIDTH-1 (last bit), the word completes: move it to the output stage, set count=0, go to IDLE.
- bit_valid=0: hold all state. There is no gap timeout.
- bit_valid=1 and sof=1:
  - set frame_err;
  - discard the partial word;
  - take this bit as bit 0 of a new word (count=1, stay in SHIFT).

Output stage on word completion:
- Load the word when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle. out_valid is then 1 after the edge.
- If out_valid=1 and out_ready=0: drop the new word, keep the old out_data, set overrun.

Acceptance:
- out_valid=1 and out_ready=1 with no completing word: out_valid=0 after the edge.
- out_data keeps its last value.

Error flags:
- clr_err=1 clears frame_err and overrun at the edge.
- If a set event and clr_err occur in the same cycle, the set wins and the flag ends at 1.

busy=1 exactly while the state is SHIFT.

## Timing

- Latency: the last bit is sampled at edge N. out_valid and out_data are updated at edge N, so they are visible in the following cycle.
- Minimum spacing is one word per WIDTH cycles. A sof on the cycle right after a last bit is legal back-to-back input.
- Throughput is one word per WIDTH cycles when out_ready is held at 1. Overrun cannot occur in that case.
- out_data and out_valid must not change while out_valid=1 and out_ready=0, except through asynchronous reset.
- Reset asserted mid-word: the partial word is lost immediately, including any pending out_valid. The first legal input after rst rises is a sof bit.
- All outputs are registered; there is no combinational path from input to output.

## Test plan

- Basic word, WIDTH=8: send sof with bits 0,1,0,1,1,0,1,0 (LSB first) on consecutive cycles, out_ready=1. Expect out_data=8'h5A and out_valid=1 for one cycle after the 8th edge. busy=1 for 7 cycles; both flags stay 0.
- Gapped input: same word with bit_valid=0 for 3 cycles after bit 3. Expect out_data=8'h5A with out_valid delayed by 3 cycles and busy held through the gap.
- Frame error: sof plus 4 bits, then sof plus the 8 bits of 8'hC3. Expect frame_err=1 after the second sof edge, a single out_data=8'hC3, and no word from the partial. Then pulse clr_err and expect frame_err=0.
- Overrun and backpressure: out_ready=0; send 8'h11 then 8'h22 back-to-back. Expect out_data stays 8'h11, out_valid=1, overrun=1. Raise out_ready and expect out_valid=0 next cycle.
- Simultaneous accept and complete: out_valid=1 holding 8'h11, with out_ready=1 on the edge where 8'h22 completes. Expect out_data=8'h22, out_valid=1, overrun=0.
- Async reset mid-word: drive rst=0 between edges after 5 bits with out_valid=1. Expect all outputs 0 immediately. After release, a stray non-sof bit is ignored and a full 8'hFF word is received correctly.
